// File: rtl/mxu_pkg.sv
// mxu_pkg
// Shared definitions for the mxu systolic-array control path: the matrix
// multiply sequencer state encoding, default array geometry, the width of
// the sequencer's per-state step counter, and lane-slice helpers used to
// locate one NUM_SIZE-wide lane inside a packed lane bus.
// No ports (package).
package mxu_pkg;

  // Default array geometry; the top-level accelerator uses the same values.
  localparam int DEF_NUM_SIZE  = 16;
  localparam int DEF_GRID_SIZE = 2;

  // Width of the per-state step counter inside the sequencer.
  localparam int SEQ_CNT_W = 8;

  // Sequencer phases, in execution order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    FEED   = 3'd3,
    DRAIN  = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6
  } mxu_state_t;

  // Lowest bit of lane 'lane' in a bus of lanes that are 'laneW' bits wide.
  function automatic int laneLsb(input int lane, input int laneW);
    return lane * laneW;
  endfunction

  // Total width of a bus carrying 'lanes' lanes of 'laneW' bits each.
  function automatic int laneBusWidth(input int lanes, input int laneW);
    return lanes * laneW;
  endfunction

endpackage

// File: rtl/mxu_skew_feeder.sv
// mxu_skew_feeder
// Combinational operand skewing for the systolic array. At feed step t,
// west lane i carries A[i][t-i] and north lane j carries B[t-j][j]; lanes
// whose index falls outside the matrix carry 0.
// Ports:
//   i_enable  - drive lanes when high, otherwise all lanes are 0
//   i_step    - feed step t
//   i_a_ops   - A operands, element (r,c) at lane r*GRID_SIZE+c
//   i_b_ops   - B operands, same packing
//   o_west    - west lanes, lane i at [(i+1)*NUM_SIZE-1 : i*NUM_SIZE]
//   o_north   - north lanes, same packing
module mxu_skew_feeder
  import mxu_pkg::*;
#(
  parameter int NUM_SIZE  = DEF_NUM_SIZE,
  parameter int GRID_SIZE = DEF_GRID_SIZE,
  parameter int STEP_W    = SEQ_CNT_W
) (
  input  logic                                    i_enable,
  input  logic [STEP_W-1:0]                       i_step,
  input  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] i_a_ops,
  input  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] i_b_ops,
  output logic [NUM_SIZE*GRID_SIZE-1:0]           o_west,
  output logic [NUM_SIZE*GRID_SIZE-1:0]           o_north
);

  // Element (r,c) of A enters west lane r at step r+c, and element (r,c)
  // of B enters north lane c at that same step, so a single diagonal test
  // selects both operands.
  always_comb begin
    o_west  = '0;
    o_north = '0;
    if (i_enable) begin
      for (int r = 0; r < GRID_SIZE; r++) begin
        for (int c = 0; c < GRID_SIZE; c++) begin
          if (i_step == STEP_W'(r + c)) begin
            o_west[laneLsb(r, NUM_SIZE) +: NUM_SIZE] =
              i_a_ops[laneLsb(r * GRID_SIZE + c, NUM_SIZE) +: NUM_SIZE];
            o_north[laneLsb(c, NUM_SIZE) +: NUM_SIZE] =
              i_b_ops[laneLsb(r * GRID_SIZE + c, NUM_SIZE) +: NUM_SIZE];
          end
        end
      end
    end
  end

endmodule

// File: rtl/mxu_sequencer.sv
// mxu_sequencer
// Runs one GRID_SIZE x GRID_SIZE matrix multiply per accepted command:
// loads A then B from byte-wide scratch memory, feeds them skewed into the
// systolic array, lets the array drain, writes C back row-major and pulses
// done.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   cmd_valid / cmd_ready     - command handshake (ready only when idle)
//   cmd_a/b/c_addr            - base addresses of A, B and C (row-major)
//   mem_rd_addr / mem_rd_data - scratch read port (data combinational)
//   mem_wr_en/addr/data       - scratch write port
//   mxu_clr, mxu_ce           - array accumulator clear and clock enable
//   mxu_north, mxu_west       - array input lanes
//   mxu_result                - array accumulators, lane k = i*G+j
//   busy, done                - status: not idle / one-cycle completion
module mxu_sequencer
  import mxu_pkg::*;
#(
  parameter int NUM_SIZE     = DEF_NUM_SIZE,
  parameter int GRID_SIZE    = DEF_GRID_SIZE,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [ADDR_W-1:0]                       cmd_a_addr,
  input  logic [ADDR_W-1:0]                       cmd_b_addr,
  input  logic [ADDR_W-1:0]                       cmd_c_addr,
  output logic [ADDR_W-1:0]                       mem_rd_addr,
  input  logic [DATA_W-1:0]                       mem_rd_data,
  output logic                                    mem_wr_en,
  output logic [ADDR_W-1:0]                       mem_wr_addr,
  output logic [DATA_W-1:0]                       mem_wr_data,
  output logic                                    mxu_clr,
  output logic                                    mxu_ce,
  output logic [NUM_SIZE*GRID_SIZE-1:0]           mxu_north,
  output logic [NUM_SIZE*GRID_SIZE-1:0]           mxu_west,
  input  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] mxu_result,
  output logic                                    busy,
  output logic                                    done
);

  localparam int CELLS = GRID_SIZE * GRID_SIZE;
  localparam int CNT_W = SEQ_CNT_W;
  localparam int OPS_W = laneBusWidth(CELLS, NUM_SIZE);

  mxu_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_a_base;
  logic [ADDR_W-1:0] r_b_base;
  logic [ADDR_W-1:0] r_c_base;
  logic [OPS_W-1:0]  r_a_ops;
  logic [OPS_W-1:0]  r_b_ops;

  mxu_state_t        w_state_after;
  logic [CNT_W-1:0]  w_cnt_last;
  logic              w_cnt_done;
  logic [NUM_SIZE-1:0] w_rd_ext;
  logic [DATA_W-1:0] w_result_byte;
  logic              w_unused;

  // Operands are unsigned bytes widened to the lane width.
  assign w_rd_ext = NUM_SIZE'(mem_rd_data);

  // Only the low DATA_W bits of each result lane reach memory.
  assign w_unused = ^{1'b0, mxu_result};

  // Length of the current phase and the phase that follows it. The step
  // counter restarts at 0 on every phase change.
  always_comb begin
    w_cnt_last    = '0;
    w_state_after = IDLE;
    case (r_state)
      LOAD_A: begin
        w_cnt_last    = CNT_W'(CELLS - 1);
        w_state_after = LOAD_B;
      end
      LOAD_B: begin
        w_cnt_last    = CNT_W'(CELLS - 1);
        w_state_after = FEED;
      end
      FEED: begin
        w_cnt_last    = CNT_W'(2 * GRID_SIZE - 2);
        w_state_after = DRAIN;
      end
      DRAIN: begin
        w_cnt_last    = CNT_W'(DRAIN_CYCLES - 1);
        w_state_after = WRITE;
      end
      WRITE: begin
        w_cnt_last    = CNT_W'(CELLS - 1);
        w_state_after = DONE;
      end
      default: begin
        w_cnt_last    = '0;
        w_state_after = IDLE;
      end
    endcase
  end

  assign w_cnt_done = (r_cnt == w_cnt_last);

  // Phase sequencing, command capture and operand capture. A reset throws
  // away any command in flight, so the next edge after it is idle again.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_c_base <= '0;
      r_a_ops  <= '0;
      r_b_ops  <= '0;
    end else begin
      if (r_state == IDLE) begin
        if (cmd_valid) begin
          r_a_base <= cmd_a_addr;
          r_b_base <= cmd_b_addr;
          r_c_base <= cmd_c_addr;
          r_cnt    <= '0;
          r_state  <= LOAD_A;
        end
      end else if (w_cnt_done) begin
        r_cnt   <= '0;
        r_state <= w_state_after;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // Step n of a load phase fills element n, i.e. row n/G, column n%G.
      for (int k = 0; k < CELLS; k++) begin
        if (r_cnt == CNT_W'(k)) begin
          if (r_state == LOAD_A) begin
            r_a_ops[laneLsb(k, NUM_SIZE) +: NUM_SIZE] <= w_rd_ext;
          end
          if (r_state == LOAD_B) begin
            r_b_ops[laneLsb(k, NUM_SIZE) +: NUM_SIZE] <= w_rd_ext;
          end
        end
      end
    end
  end

  // Result lane selected by the write step.
  always_comb begin
    w_result_byte = '0;
    for (int k = 0; k < CELLS; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_result_byte = mxu_result[laneLsb(k, NUM_SIZE) +: DATA_W];
      end
    end
  end

  // Status, memory and array controls all decode straight from the phase,
  // so a reset takes effect on every output at the same edge.
  always_comb begin
    cmd_ready   = (r_state == IDLE);
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    mxu_clr     = (r_state == LOAD_A) && (r_cnt == '0);
    mxu_ce      = (r_state == FEED) || (r_state == DRAIN);
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (r_state == LOAD_A) begin
      mem_rd_addr = r_a_base + ADDR_W'(r_cnt);
    end else if (r_state == LOAD_B) begin
      mem_rd_addr = r_b_base + ADDR_W'(r_cnt);
    end
    if (r_state == WRITE) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = r_c_base + ADDR_W'(r_cnt);
      mem_wr_data = w_result_byte;
    end
  end

  mxu_skew_feeder #(
    .NUM_SIZE (NUM_SIZE),
    .GRID_SIZE(GRID_SIZE),
    .STEP_W   (CNT_W)
  ) u_feeder (
    .i_enable(r_state == FEED),
    .i_step  (r_cnt),
    .i_a_ops (r_a_ops),
    .i_b_ops (r_b_ops),
    .o_west  (mxu_west),
    .o_north (mxu_north)
  );

endmodule

// File: tb/tb_mxu_sequencer.sv
// tb_mxu_sequencer
// Drives mxu_sequencer against a byte-wide scratch memory and a behavioural
// output-stationary systolic array. Expected C writes are computed from the
// memory contents when a command is accepted and queued; every write strobe
// pops and compares one entry.
module tb_mxu_sequencer;

  localparam int NS = 16;
  localparam int G  = 2;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DR = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wrExp_t;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [AW-1:0]     cmd_a_addr;
  logic [AW-1:0]     cmd_b_addr;
  logic [AW-1:0]     cmd_c_addr;
  logic [AW-1:0]     mem_rd_addr;
  logic [DW-1:0]     mem_rd_data;
  logic              mem_wr_en;
  logic [AW-1:0]     mem_wr_addr;
  logic [DW-1:0]     mem_wr_data;
  logic              mxu_clr;
  logic              mxu_ce;
  logic [NS*G-1:0]   mxu_north;
  logic [NS*G-1:0]   mxu_west;
  logic [NS*G*G-1:0] mxu_result;
  logic              busy;
  logic              done;

  logic [DW-1:0] mem [32];
  logic [NS-1:0] accM  [G][G];
  logic [NS-1:0] aPipe [G][G];
  logic [NS-1:0] bPipe [G][G];

  wrExp_t expQ[$];
  int     checkCount = 0;
  int     failCount  = 0;
  int     wrStrobes  = 0;
  int     cyc        = 0;

  mxu_sequencer #(
    .NUM_SIZE    (NS),
    .GRID_SIZE   (G),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .DRAIN_CYCLES(DR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a_addr (cmd_a_addr),
    .cmd_b_addr (cmd_b_addr),
    .cmd_c_addr (cmd_c_addr),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mxu_clr    (mxu_clr),
    .mxu_ce     (mxu_ce),
    .mxu_north  (mxu_north),
    .mxu_west   (mxu_west),
    .mxu_result (mxu_result),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratch memory read port is combinational.
  assign mem_rd_data = mem[mem_rd_addr];

  // Behavioural array: each PE multiplies the values arriving from west and
  // north, accumulates, and passes them east and south one cycle later.
  always @(posedge clk) begin
    logic [NS-1:0] aIn;
    logic [NS-1:0] bIn;
    for (int i = 0; i < G; i++) begin
      for (int j = 0; j < G; j++) begin
        if (rst || mxu_clr) begin
          accM[i][j]  <= '0;
          aPipe[i][j] <= '0;
          bPipe[i][j] <= '0;
        end else if (mxu_ce) begin
          if (j == 0) aIn = mxu_west[i*NS +: NS];
          else        aIn = aPipe[i][j-1];
          if (i == 0) bIn = mxu_north[j*NS +: NS];
          else        bIn = bPipe[i-1][j];
          accM[i][j]  <= accM[i][j] + aIn * bIn;
          aPipe[i][j] <= aIn;
          bPipe[i][j] <= bIn;
        end
      end
    end
  end

  // Accumulators presented as result lanes, lane k = i*G+j.
  always_comb begin
    mxu_result = '0;
    for (int i = 0; i < G; i++) begin
      for (int j = 0; j < G; j++) begin
        mxu_result[(i*G+j)*NS +: NS] = accM[i][j];
      end
    end
  end

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation,
  // then the write lands in the scratch memory.
  always @(negedge clk) begin
    wrExp_t e;
    if (mem_wr_en) begin
      wrStrobes++;
      checkOutput("write expected", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("wr addr", 64'(mem_wr_addr), 64'(e.addr));
        checkOutput("wr data", 64'(mem_wr_data), 64'(e.data));
      end
      mem[mem_wr_addr] = mem_wr_data;
    end
  end

  // Golden C = A x B from the current memory contents, 8-bit wrapping.
  task automatic pushExpected(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
    logic [DW-1:0] sum;
    logic [AW-1:0] addrA;
    logic [AW-1:0] addrB;
    wrExp_t        e;
    for (int i = 0; i < G; i++) begin
      for (int j = 0; j < G; j++) begin
        sum = '0;
        for (int k = 0; k < G; k++) begin
          addrA = a + AW'(i*G + k);
          addrB = b + AW'(k*G + j);
          sum   = sum + mem[addrA] * mem[addrB];
        end
        e.addr = c + AW'(i*G + j);
        e.data = sum;
        expQ.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
    cmd_valid  = v;
    cmd_a_addr = a;
    cmd_b_addr = b;
    cmd_c_addr = c;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic waitForDone(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      nextCycle();
      n++;
    end
    checkOutput("done within budget", 64'(done), 64'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    logic [AW-1:0] expRd [4];
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, '0);
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset wr_en", 64'(mem_wr_en), 64'd0);
    checkOutput("reset ce", 64'(mxu_ce), 64'd0);
    checkOutput("reset clr", 64'(mxu_clr), 64'd0);
    checkOutput("reset west", 64'(mxu_west), 64'd0);
    checkOutput("reset north", 64'(mxu_north), 64'd0);
    checkOutput("reset rd_addr", 64'(mem_rd_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic multiply with cycle-exact phase and skew checks.
    $display("[TB] basic multiply");
    for (int i = 0; i < 8; i++) mem[i] = DW'(i + 1);
    cyc = 0;
    wrStrobes = 0;
    applyStimulus(1'b1, 5'd0, 5'd4, 5'd8);
    checkOutput("accept ready", 64'(cmd_ready), 64'd1);
    pushExpected(5'd0, 5'd4, 5'd8);
    for (int k = 1; k <= 19; k++) begin
      nextCycle();
      if (k == 1) begin
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("c1 clr", 64'(mxu_clr), 64'd1);
        checkOutput("c1 busy", 64'(busy), 64'd1);
        checkOutput("c1 ready", 64'(cmd_ready), 64'd0);
        checkOutput("c1 rd_addr", 64'(mem_rd_addr), 64'd0);
      end
      if (k == 2) begin
        checkOutput("c2 clr", 64'(mxu_clr), 64'd0);
        checkOutput("c2 rd_addr", 64'(mem_rd_addr), 64'd1);
      end
      if (k == 5) checkOutput("c5 rd_addr", 64'(mem_rd_addr), 64'd4);
      if (k == 9) begin
        checkOutput("c9 ce", 64'(mxu_ce), 64'd1);
        checkOutput("c9 west", 64'(mxu_west), 64'h0000_0001);
        checkOutput("c9 north", 64'(mxu_north), 64'h0000_0005);
      end
      if (k == 10) begin
        checkOutput("c10 west", 64'(mxu_west), 64'h0003_0002);
        checkOutput("c10 north", 64'(mxu_north), 64'h0006_0007);
      end
      if (k == 11) begin
        checkOutput("c11 west", 64'(mxu_west), 64'h0004_0000);
        checkOutput("c11 north", 64'(mxu_north), 64'h0008_0000);
      end
      if (k == 12) begin
        checkOutput("c12 ce", 64'(mxu_ce), 64'd1);
        checkOutput("c12 west", 64'(mxu_west), 64'd0);
        checkOutput("c12 north", 64'(mxu_north), 64'd0);
      end
      if (k == 13) checkOutput("c13 ce", 64'(mxu_ce), 64'd1);
      if (k == 14) begin
        checkOutput("c14 ce", 64'(mxu_ce), 64'd0);
        checkOutput("c14 wr_en", 64'(mem_wr_en), 64'd1);
        checkOutput("c14 wr_addr", 64'(mem_wr_addr), 64'd8);
        checkOutput("c14 rd_addr", 64'(mem_rd_addr), 64'd0);
      end
      if (k == 17) checkOutput("c17 done", 64'(done), 64'd0);
      if (k == 18) begin
        checkOutput("c18 done", 64'(done), 64'd1);
        checkOutput("c18 busy", 64'(busy), 64'd1);
        checkOutput("c18 wr_en", 64'(mem_wr_en), 64'd0);
      end
      if (k == 19) begin
        checkOutput("c19 done", 64'(done), 64'd0);
        checkOutput("c19 ready", 64'(cmd_ready), 64'd1);
        checkOutput("c19 busy", 64'(busy), 64'd0);
      end
    end
    checkOutput("basic strobes", 64'(wrStrobes), 64'd4);
    checkOutput("basic queue empty", 64'(expQ.size()), 64'd0);
    checkOutput("basic mem8", 64'(mem[8]), 64'd19);
    checkOutput("basic mem9", 64'(mem[9]), 64'd22);
    checkOutput("basic mem10", 64'(mem[10]), 64'd43);
    checkOutput("basic mem11", 64'(mem[11]), 64'd50);

    // Address wrap and result truncation.
    $display("[TB] truncation and wrap");
    mem[30] = 8'd16; mem[31] = 8'd16; mem[0] = 8'd16; mem[1] = 8'd16;
    mem[4] = 8'd16;  mem[5] = 8'd0;   mem[6] = 8'd0;  mem[7] = 8'd16;
    expRd[0] = 5'd30; expRd[1] = 5'd31; expRd[2] = 5'd0; expRd[3] = 5'd1;
    cyc = 0;
    wrStrobes = 0;
    applyStimulus(1'b1, 5'd30, 5'd4, 5'd8);
    pushExpected(5'd30, 5'd4, 5'd8);
    for (int k = 1; k <= 19; k++) begin
      nextCycle();
      if (k == 1) applyStimulus(1'b0, '0, '0, '0);
      if (k <= 4) checkOutput("wrap rd_addr", 64'(mem_rd_addr), 64'(expRd[k-1]));
      if (k == 18) checkOutput("wrap done", 64'(done), 64'd1);
    end
    checkOutput("wrap strobes", 64'(wrStrobes), 64'd4);
    checkOutput("wrap queue empty", 64'(expQ.size()), 64'd0);
    for (int i = 8; i < 12; i++) checkOutput("wrap mem zero", 64'(mem[i]), 64'd0);

    // Back-to-back commands with cmd_valid held high.
    $display("[TB] back-to-back");
    for (int i = 0; i < 8; i++) mem[i] = DW'(i + 1);
    cyc = 0;
    wrStrobes = 0;
    applyStimulus(1'b1, 5'd0, 5'd4, 5'd8);
    pushExpected(5'd0, 5'd4, 5'd8);
    for (int k = 1; k <= 20; k++) begin
      nextCycle();
      if (k == 1) begin
        checkOutput("b2b c1 clr", 64'(mxu_clr), 64'd1);
        applyStimulus(1'b1, 5'd8, 5'd4, 5'd12);
      end
      if (k == 2) checkOutput("b2b c2 clr", 64'(mxu_clr), 64'd0);
      if (k == 18) begin
        checkOutput("b2b c18 ready", 64'(cmd_ready), 64'd0);
        checkOutput("b2b c18 done", 64'(done), 64'd1);
      end
      if (k == 19) begin
        checkOutput("b2b c19 ready", 64'(cmd_ready), 64'd1);
        checkOutput("b2b c19 clr", 64'(mxu_clr), 64'd0);
        pushExpected(5'd8, 5'd4, 5'd12);
      end
      if (k == 20) begin
        checkOutput("b2b c20 clr", 64'(mxu_clr), 64'd1);
        checkOutput("b2b c20 busy", 64'(busy), 64'd1);
        applyStimulus(1'b0, '0, '0, '0);
      end
    end
    waitForDone(40);
    nextCycle();
    checkOutput("b2b strobes", 64'(wrStrobes), 64'd8);
    checkOutput("b2b queue empty", 64'(expQ.size()), 64'd0);
    checkOutput("b2b mem12", 64'(mem[12]), 64'd249);
    checkOutput("b2b mem13", 64'(mem[13]), 64'd34);
    checkOutput("b2b mem14", 64'(mem[14]), 64'd53);
    checkOutput("b2b mem15", 64'(mem[15]), 64'd146);

    // Reset during FEED abandons the command; a fresh command then works.
    $display("[TB] reset mid-operation");
    cyc = 0;
    wrStrobes = 0;
    applyStimulus(1'b1, 5'd0, 5'd4, 5'd16);
    for (int k = 1; k <= 12; k++) begin
      nextCycle();
      if (k == 1) applyStimulus(1'b0, '0, '0, '0);
      if (k == 10) begin
        checkOutput("abort c10 ce", 64'(mxu_ce), 64'd1);
        rst = 1'b1;
      end
      if (k == 11) begin
        checkOutput("abort c11 ce", 64'(mxu_ce), 64'd0);
        checkOutput("abort c11 busy", 64'(busy), 64'd0);
        checkOutput("abort c11 wr_en", 64'(mem_wr_en), 64'd0);
        rst = 1'b0;
      end
      if (k == 12) begin
        checkOutput("abort c12 ready", 64'(cmd_ready), 64'd1);
        checkOutput("abort c12 busy", 64'(busy), 64'd0);
      end
    end
    repeat (20) nextCycle();
    checkOutput("abort no writes", 64'(wrStrobes), 64'd0);
    checkOutput("abort mem16 untouched", 64'(mem[16]), 64'd0);
    applyStimulus(1'b1, 5'd0, 5'd4, 5'd16);
    pushExpected(5'd0, 5'd4, 5'd16);
    nextCycle();
    applyStimulus(1'b0, '0, '0, '0);
    waitForDone(30);
    nextCycle();
    checkOutput("after abort strobes", 64'(wrStrobes), 64'd4);
    checkOutput("after abort queue empty", 64'(expQ.size()), 64'd0);
    checkOutput("after abort mem16", 64'(mem[16]), 64'd19);
    checkOutput("after abort mem19", 64'(mem[19]), 64'd50);

    // A command offered while busy is ignored.
    $display("[TB] busy ignore");
    for (int i = 24; i < 28; i++) mem[i] = 8'hAA;
    cyc = 0;
    wrStrobes = 0;
    applyStimulus(1'b1, 5'd0, 5'd4, 5'd20);
    pushExpected(5'd0, 5'd4, 5'd20);
    for (int k = 1; k <= 19; k++) begin
      nextCycle();
      if (k == 1) applyStimulus(1'b0, '0, '0, '0);
      if (k == 5) begin
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd24);
        checkOutput("ignore c5 ready", 64'(cmd_ready), 64'd0);
      end
      if (k == 6) begin
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("ignore c6 clr", 64'(mxu_clr), 64'd0);
        checkOutput("ignore c6 rd_addr", 64'(mem_rd_addr), 64'd5);
      end
      if (k == 18) checkOutput("ignore c18 done", 64'(done), 64'd1);
    end
    nextCycle();
    checkOutput("ignore stays idle", 64'(busy), 64'd0);
    checkOutput("ignore strobes", 64'(wrStrobes), 64'd4);
    checkOutput("ignore queue empty", 64'(expQ.size()), 64'd0);
    checkOutput("ignore mem20", 64'(mem[20]), 64'd19);
    checkOutput("ignore mem24", 64'(mem[24]), 64'hAA);
    checkOutput("ignore mem27", 64'(mem[27]), 64'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
